// File: rtl/ram_pkg.sv
// Shared types and constants for the data-RAM controller and its storage array.
package ram_pkg;

  localparam logic [15:0] RAM_BOUND_L = 16'h0200;
  localparam logic [15:0] RAM_BOUND_U = 16'h0400;
  localparam int unsigned WAIT_CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Request fields captured when a request is accepted in IDLE.
  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] din;
    logic        we;
    logic        bw;
  } ram_req_t;

  function automatic logic in_window(input logic [15:0] addr,
                                     input logic [15:0] lo,
                                     input logic [15:0] hi);
    return (addr >= lo) && (addr < hi);
  endfunction

endpackage

// File: rtl/ram_ctrl_array.sv
// Byte-wide RAM organised as even/odd lanes with per-lane write enables and a 2-byte read port.
// With RAM_CTRL_PARITY_EN defined each byte carries an even-parity bit checked on read.
module ram_ctrl_array #(
  parameter int unsigned WORDS = 256,
  parameter int unsigned IW    = 8
) (
  input  logic          clk,
  input  logic [IW-1:0] idx,
  input  logic          we_lo,
  input  logic          we_hi,
  input  logic [7:0]    wdata_lo,
  input  logic [7:0]    wdata_hi,
  output logic [15:0]   rdata_c
`ifdef RAM_CTRL_PARITY_EN
  ,
  output logic [1:0]    rpar_bad_c
`endif
);

  logic [7:0] mem_lo [WORDS];
  logic [7:0] mem_hi [WORDS];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_lo) mem_lo[idx] <= wdata_lo;
    if (we_hi) mem_hi[idx] <= wdata_hi;
  end

  assign rdata_c = {mem_hi[idx], mem_lo[idx]};

`ifdef RAM_CTRL_PARITY_EN
  logic par_lo [WORDS];
  logic par_hi [WORDS];

  always_ff @(posedge clk) begin
    if (we_lo) par_lo[idx] <= ^wdata_lo;
    if (we_hi) par_hi[idx] <= ^wdata_hi;
  end

  // A lane is bad when data plus its stored bit has odd parity.
  assign rpar_bad_c = {^{mem_hi[idx], par_hi[idx]}, ^{mem_lo[idx], par_lo[idx]}};
`endif

endmodule

// File: rtl/ram_ctrl.sv
// Data-RAM controller: req/ack slave over the byte window [BOUND_L, BOUND_U) with wait states.
// Optional parity storage and par_err output are enabled by defining RAM_CTRL_PARITY_EN.
module ram_ctrl
  import ram_pkg::*;
#(
  parameter logic [15:0] BOUND_L     = RAM_BOUND_L,
  parameter logic [15:0] BOUND_U     = RAM_BOUND_U,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [15:0] addr,
  input  logic [15:0] din,
  input  logic        we,
  input  logic        bw,
  output logic        ack,
  output logic [15:0] dout,
  output logic        err,
  output logic        busy
`ifdef RAM_CTRL_PARITY_EN
  ,
  output logic        par_err
`endif
);

  localparam int unsigned SIZE  = 32'(BOUND_U) - 32'(BOUND_L);
  localparam int unsigned AW    = $clog2(SIZE);
  localparam int unsigned WORDS = SIZE / 2;
  localparam int unsigned IW    = AW - 1;

  state_t                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  ram_req_t              req_q, req_d;
  logic                  ack_d, err_d, busy_d;
  logic [15:0]           dout_d;

  logic                  hit_c;
  logic [AW-1:0]         off_c;
  logic [15:0]           rdata_c;
  logic [7:0]            rbyte_c;
  logic [7:0]            wdata_hi_c;
  logic                  we_lo_c, we_hi_c;

`ifdef RAM_CTRL_PARITY_EN
  logic                  par_err_d;
  logic [1:0]            rpar_bad_c;
`endif

  // Decode of the latched request; odd offset selects the high lane.
  assign hit_c      = in_window(req_q.addr, BOUND_L, BOUND_U);
  assign off_c      = AW'(req_q.addr - BOUND_L);
  assign rbyte_c    = off_c[0] ? rdata_c[15:8] : rdata_c[7:0];
  assign wdata_hi_c = req_q.bw ? req_q.din[7:0] : req_q.din[15:8];

  ram_ctrl_array #(
    .WORDS (WORDS),
    .IW    (IW)
  ) u_array (
    .clk      (clk),
    .idx      (off_c[AW-1:1]),
    .we_lo    (we_lo_c),
    .we_hi    (we_hi_c),
    .wdata_lo (req_q.din[7:0]),
    .wdata_hi (wdata_hi_c),
    .rdata_c  (rdata_c)
`ifdef RAM_CTRL_PARITY_EN
    ,
    .rpar_bad_c (rpar_bad_c)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      dout    <= 16'h0000;
`ifdef RAM_CTRL_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ack     <= ack_d;
      err     <= err_d;
      busy    <= busy_d;
      dout    <= dout_d;
`ifdef RAM_CTRL_PARITY_EN
      par_err <= par_err_d;
`endif
    end
  end

  // Next state, next registered outputs and array write enables.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dout_d  = dout;
    we_lo_c = 1'b0;
    we_hi_c = 1'b0;
`ifdef RAM_CTRL_PARITY_EN
    par_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (req) begin
          req_d.addr = addr;
          req_d.din  = din;
          req_d.we   = we;
          req_d.bw   = bw;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_CNT_W'(WAIT_STATES - 1);
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = ACCESS;
        else             cnt_d   = cnt_q - WAIT_CNT_W'(1);
      end
      ACCESS: begin
        state_d = IDLE;
        ack_d   = 1'b1;
        err_d   = !hit_c;
        if (!hit_c) begin
          dout_d = 16'h0000;
        end else if (req_q.we) begin
          we_lo_c = !req_q.bw || !off_c[0];
          we_hi_c = !req_q.bw ||  off_c[0];
        end else begin
          dout_d = req_q.bw ? {8'h00, rbyte_c} : rdata_c;
`ifdef RAM_CTRL_PARITY_EN
          par_err_d = req_q.bw ? (off_c[0] ? rpar_bad_c[1] : rpar_bad_c[0]) : |rpar_bad_c;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: one instance with no wait states, one with three, against a byte-array model.
`timescale 1ns/1ps
module tb_ram_ctrl;

  localparam logic [15:0] BL   = 16'h0200;
  localparam logic [15:0] BU   = 16'h0400;
  localparam int          WS_A = 0;
  localparam int          WS_B = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_v  [2];
  logic [15:0] addr_v [2];
  logic [15:0] din_v  [2];
  logic        we_v   [2];
  logic        bw_v   [2];

  logic        ack0, err0, busy0, ack3, err3, busy3;
  logic [15:0] dout0, dout3;
`ifdef RAM_CTRL_PARITY_EN
  logic        pe0, pe3;
`endif

  ram_ctrl #(.BOUND_L(BL), .BOUND_U(BU), .WAIT_STATES(WS_A)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req_v[0]), .addr(addr_v[0]), .din(din_v[0]),
    .we(we_v[0]), .bw(bw_v[0]), .ack(ack0), .dout(dout0), .err(err0), .busy(busy0)
`ifdef RAM_CTRL_PARITY_EN
    , .par_err(pe0)
`endif
  );

  ram_ctrl #(.BOUND_L(BL), .BOUND_U(BU), .WAIT_STATES(WS_B)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req_v[1]), .addr(addr_v[1]), .din(din_v[1]),
    .we(we_v[1]), .bw(bw_v[1]), .ack(ack3), .dout(dout3), .err(err3), .busy(busy3)
`ifdef RAM_CTRL_PARITY_EN
    , .par_err(pe3)
`endif
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  string       ctx      = "init";
  logic [7:0]  mdl [2][512];
  logic [15:0] last_dout [2];
  logic        exp_pe [2];

  function automatic logic o_ack(input int s);  return (s == 0) ? ack0  : ack3;  endfunction
  function automatic logic o_err(input int s);  return (s == 0) ? err0  : err3;  endfunction
  function automatic logic o_busy(input int s); return (s == 0) ? busy0 : busy3; endfunction
  function automatic logic [15:0] o_dout(input int s); return (s == 0) ? dout0 : dout3; endfunction
  function automatic int ws(input int s); return (s == 0) ? WS_A : WS_B; endfunction
`ifdef RAM_CTRL_PARITY_EN
  function automatic logic o_pe(input int s); return (s == 0) ? pe0 : pe3; endfunction
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0h expected %0h", ctx, tag, obs, exp);
    end
  endtask

  // Reference: window test, word alignment, byte lanes, held read data.
  function automatic void model(input int s, input logic [15:0] a, input logic [15:0] d,
                                input logic w, input logic b,
                                output logic [15:0] ed, output logic ee);
    int o;
    ee = !((a >= BL) && (a < BU));
    if (ee) begin
      last_dout[s] = 16'h0000;
    end else begin
      o = int'(a - BL);
      if (!b) o = o & ~1;
      if (w) begin
        mdl[s][o] = d[7:0];
        if (!b) mdl[s][o+1] = d[15:8];
      end else begin
        last_dout[s] = b ? {8'h00, mdl[s][o]} : {mdl[s][o+1], mdl[s][o]};
      end
    end
    ed = last_dout[s];
  endfunction

  task automatic access(input int s, input logic [15:0] a, input logic [15:0] d,
                        input logic w, input logic b, output logic [15:0] od);
    logic [15:0] ed;
    logic        ee;
    int          n;
    bit          got;
    model(s, a, d, w, b, ed, ee);
    @(negedge clk);
    req_v[s] = 1'b1; addr_v[s] = a; din_v[s] = d; we_v[s] = w; bw_v[s] = b;
    n = 0; got = 0;
    while (!got && n < 16) begin
      @(posedge clk); #1;
      n++;
      req_v[s] = 1'b0;
      if (o_ack(s)) got = 1;
      else begin
        chk("busy_mid", 32'(o_busy(s)), 32'd1);
        chk("err_idle", 32'(o_err(s)), 32'd0);
      end
    end
    chk("latency", 32'(n), 32'(ws(s) + 2));
    chk("err", 32'(o_err(s)), 32'(ee));
    chk("dout", 32'(o_dout(s)), 32'(ed));
    chk("busy_ack", 32'(o_busy(s)), 32'd0);
`ifdef RAM_CTRL_PARITY_EN
    chk("par_err", 32'(o_pe(s)), 32'((!w && !ee) ? exp_pe[s] : 1'b0));
`endif
    od = o_dout(s);
    @(posedge clk); #1;
    chk("ack_pulse", 32'(o_ack(s)), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] od, ed3 [3], old;
    logic        ee;
    logic [15:0] b2b_a [3];
    logic        b2b_bw [3];
    int          n;
    bit          got;

    for (int s = 0; s < 2; s++) begin
      req_v[s] = 0; addr_v[s] = '0; din_v[s] = '0; we_v[s] = 0; bw_v[s] = 0;
      last_dout[s] = 16'h0000; exp_pe[s] = 1'b0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #20;
    ctx = "reset";
    chk("ack0", 32'(ack0), 0); chk("err0", 32'(err0), 0); chk("busy0", 32'(busy0), 0);
    chk("dout0", 32'(dout0), 0);
    chk("ack3", 32'(ack3), 0); chk("err3", 32'(err3), 0); chk("busy3", 32'(busy3), 0);
    chk("dout3", 32'(dout3), 0);
    @(negedge clk); rst_n = 1'b1;

    ctx = "preload";
    for (int s = 0; s < 2; s++)
      for (int o = 0; o < 512; o += 2)
        access(s, BL + 16'(o), 16'($urandom), 1'b1, 1'b0, od);

    ctx = "word_rw";
    access(0, 16'h0200, 16'hBEEF, 1'b1, 1'b0, od);
    access(0, 16'h0200, 16'h0000, 1'b0, 1'b0, od);
    chk("beef", 32'(od), 32'h0000BEEF);

    ctx = "byte_rw";
    access(0, 16'h0203, 16'h12A5, 1'b1, 1'b1, od);
    access(0, 16'h0202, 16'h0000, 1'b0, 1'b0, od);
    chk("hi_byte", 32'(od[15:8]), 32'h000000A5);
    chk("lo_kept", 32'(od[7:0]), 32'(mdl[0][2]));
    access(0, 16'h0203, 16'h0000, 1'b0, 1'b1, od);
    chk("byte_rd", 32'(od), 32'h000000A5);

    ctx = "misaligned";
    access(0, 16'h0200, 16'hCAFE, 1'b1, 1'b0, od);
    access(0, 16'h0201, 16'h0000, 1'b0, 1'b0, od);
    chk("cafe", 32'(od), 32'h0000CAFE);

    ctx = "out_of_window";
    access(0, 16'h0400, 16'h1111, 1'b1, 1'b0, od);
    chk("oow_dout", 32'(od), 32'd0);
    access(0, 16'h03FE, 16'h0000, 1'b0, 1'b0, od);
    access(0, 16'h01FF, 16'h2222, 1'b1, 1'b1, od);
    access(0, 16'h03FF, 16'h0000, 1'b0, 1'b0, od);
    chk("top_word", 32'(od), 32'({mdl[0][511], mdl[0][510]}));

`ifdef RAM_CTRL_PARITY_EN
    ctx = "parity";
    access(0, 16'h0220, 16'h5A3C, 1'b1, 1'b0, od);
    dut0.u_array.par_lo[16] = ~dut0.u_array.par_lo[16];
    exp_pe[0] = 1'b1;
    access(0, 16'h0220, 16'h0000, 1'b0, 1'b0, od);
    chk("pe_data", 32'(od), 32'h00005A3C);
    exp_pe[0] = 1'b0;
    access(0, 16'h0221, 16'h0000, 1'b0, 1'b1, od);
    access(0, 16'h0222, 16'h0000, 1'b0, 1'b0, od);
    access(0, 16'h0220, 16'h5A3C, 1'b1, 1'b0, od);
`endif

    ctx = "b2b";
    b2b_a[0] = 16'h0300; b2b_bw[0] = 1'b0;
    b2b_a[1] = 16'h0305; b2b_bw[1] = 1'b1;
    b2b_a[2] = 16'h03FF; b2b_bw[2] = 1'b0;
    for (int k = 0; k < 3; k++) model(1, b2b_a[k], 16'h0000, 1'b0, b2b_bw[k], ed3[k], ee);
    @(negedge clk);
    req_v[1] = 1'b1; addr_v[1] = b2b_a[0]; we_v[1] = 1'b0; bw_v[1] = b2b_bw[0];
    for (int k = 0; k < 3; k++) begin
      n = 0; got = 0;
      while (!got && n < 16) begin
        @(posedge clk); #1;
        n++;
        if (ack3) got = 1;
        else chk("busy", 32'(busy3), 32'd1);
      end
      chk("latency", 32'(n), 32'd5);
      chk("dout", 32'(dout3), 32'(ed3[k]));
      chk("err", 32'(err3), 32'(ee));
      if (k < 2) begin
        addr_v[1] = b2b_a[k+1]; bw_v[1] = b2b_bw[k+1];
      end else begin
        req_v[1] = 1'b0;
      end
    end
    @(posedge clk); #1;
    chk("ack_end", 32'(ack3), 32'd0);

    ctx = "reset_in_wait";
    old = {mdl[1][17], mdl[1][16]};
    @(negedge clk);
    req_v[1] = 1'b1; addr_v[1] = 16'h0210; din_v[1] = ~old; we_v[1] = 1'b1; bw_v[1] = 1'b0;
    @(posedge clk); #1;
    req_v[1] = 1'b0;
    @(posedge clk); #1;
    chk("busy_wait", 32'(busy3), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy3), 32'd0); chk("rst_ack", 32'(ack3), 32'd0);
    chk("rst_dout3", 32'(dout3), 32'd0); chk("rst_dout0", 32'(dout0), 32'd0);
    last_dout[0] = 16'h0000; last_dout[1] = 16'h0000;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("no_ack", 32'(ack3), 32'd0);
    end
    access(1, 16'h0210, 16'h0000, 1'b0, 1'b0, od);
    chk("kept", 32'(od), 32'(old));

    ctx = "random";
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 40; i++)
        access(s, 16'($urandom_range(32'h01F8, 32'h0407)), 16'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), od);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
